// File: rtl/autotype_pkg.sv
// Shared types and constants for the autotype sequencer: FSM state encoding,
// onboard key bit positions and the helper that builds the default key list.
package autotype_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_PULSE,
    SETTLE,
    PRESS,
    RELEASE,
    DONE
  } state_t;

  localparam int KEY_ENTER = 0;
  localparam int KEY_B     = 1;
  localparam int KEY_C     = 2;

  // One-hot mask for a single onboard key in the default 4-bit key vector.
  function automatic logic [3:0] key_mask(input int bit_idx);
    logic [3:0] m;
    m = '0;
    m[bit_idx] = 1'b1;
    return m;
  endfunction

  // Packs six 4-bit entries so that e0 is replayed first (lowest bits).
  function automatic logic [23:0] build_seq6(input logic [3:0] e0, input logic [3:0] e1,
                                             input logic [3:0] e2, input logic [3:0] e3,
                                             input logic [3:0] e4, input logic [3:0] e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  // b, c, enter, enter, pause, enter
  localparam logic [23:0] DEFAULT_SEQ = build_seq6(key_mask(KEY_B), key_mask(KEY_C),
                                                   key_mask(KEY_ENTER), key_mask(KEY_ENTER),
                                                   4'h0, key_mask(KEY_ENTER));

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/autotype_sequencer_if.sv
// Control/status bundle between a board top-level and the autotype sequencer.
// start and abort are single-cycle requests sampled on the rising clock edge;
// there is no back-pressure: start is taken only when the sequencer is not busy
// and is otherwise dropped, abort is honoured only while busy. All status
// outputs (sys_reset_n, keys, busy, done) are registered levels.
interface autotype_sequencer_if #(
  parameter int N_KEYS = 4
);
  logic              start;
  logic              abort;
  logic              sys_reset_n;
  logic [N_KEYS-1:0] keys;
  logic              busy;
  logic              done;

  modport master (
    output start, abort,
    input  sys_reset_n, keys, busy, done
  );

  modport slave (
    input  start, abort,
    output sys_reset_n, keys, busy, done
  );
endinterface

// File: rtl/phase_timer.sv
// Down-counter used to time each sequencer phase. Load with N-1 on phase
// entry; expired is high while the count reads zero, and the counter holds
// at zero instead of wrapping.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value   = cnt;
  assign expired = (cnt == '0);

endmodule

// File: rtl/autotype_sequencer.sv
// Pulses the computer core reset, then replays a list of synthetic key
// presses with programmable hold/gap timing. Used on boards without buttons.
module autotype_sequencer
  import autotype_pkg::*;
#(
  parameter int                        N_KEYS       = 4,
  parameter int                        SEQ_LEN      = 6,
  parameter logic [SEQ_LEN*N_KEYS-1:0] SEQ          = DEFAULT_SEQ,
  parameter int                        RESET_CYCLES = 8388608,
  parameter int                        HOLD_CYCLES  = 8388608,
  parameter int                        GAP_CYCLES   = 8388608,
  parameter bit                        AUTO_START   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  autotype_sequencer_if.slave  bus,
  output state_t               dbg_state
);

  localparam int MAX_CYC = max3(RESET_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [TW-1:0] RST_LOAD  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  // The cycle in which reset is released is not yet part of the pulse, so
  // the power-up path counts one extra cycle before the pulse ends.
  localparam logic [TW-1:0] PWRUP_LOAD = TW'(RESET_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(SEQ_LEN - 1);

  if (N_KEYS < 1 || SEQ_LEN < 1 || RESET_CYCLES < 1 || HOLD_CYCLES < 1 ||
      GAP_CYCLES < 1) begin : g_bad_param
    $error("autotype_sequencer: all size/timing parameters must be >= 1");
  end

  state_t            state, nstate;
  logic [IW-1:0]     idx, nidx;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic [TW-1:0]     tmr_value;
  logic              tmr_expired;
  logic [N_KEYS-1:0] next_entry;

  logic              sys_reset_n_q;
  logic [N_KEYS-1:0] keys_q;
  logic              busy_q;
  logic              done_q;

  phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .load       (tmr_load),
    .load_value (tmr_val),
    .value      (tmr_value),
    .expired    (tmr_expired)
  );

  assign next_entry = SEQ[int'(nidx) * N_KEYS +: N_KEYS];

  // Next-state, entry index and phase-timer reload decisions.
  always_comb begin
    nstate   = state;
    nidx     = idx;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (reset) begin
      nstate   = AUTO_START ? RST_PULSE : IDLE;
      nidx     = '0;
      tmr_load = 1'b1;
      tmr_val  = PWRUP_LOAD;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            nstate   = RST_PULSE;
            nidx     = '0;
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
          end
        end
        RST_PULSE: begin
          if (bus.abort) begin
            nstate = DONE;
          end else if (tmr_expired) begin
            nstate   = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            nstate = DONE;
          end else if (tmr_expired) begin
            nstate   = PRESS;
            nidx     = '0;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        PRESS: begin
          if (bus.abort) begin
            nstate = DONE;
          end else if (tmr_expired) begin
            nstate   = RELEASE;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
        RELEASE: begin
          if (bus.abort) begin
            nstate = DONE;
          end else if (tmr_expired) begin
            if (idx == LAST_IDX) begin
              nstate = DONE;
            end else begin
              nstate   = PRESS;
              nidx     = idx + 1'b1;
              tmr_load = 1'b1;
              tmr_val  = HOLD_LOAD;
            end
          end
        end
        default: begin
          nstate = IDLE;
        end
      endcase
    end
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge clk) begin
    state <= nstate;
    idx   <= nidx;
    if (reset) begin
      sys_reset_n_q <= 1'b1;
      keys_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      sys_reset_n_q <= (nstate != RST_PULSE);
      keys_q        <= (nstate == PRESS) ? next_entry : '0;
      busy_q        <= (nstate == RST_PULSE) || (nstate == SETTLE) ||
                       (nstate == PRESS) || (nstate == RELEASE);
      done_q        <= (nstate == DONE);
    end
  end

  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.keys        = keys_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign dbg_state       = state;

endmodule
